// File: rtl/core_ctrl_fsm_pkg.sv
// Shared definitions for the core control sequencer: opcodes, funct
// fields, ALU operation encodings and the sequencer state type.
package core_ctrl_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  // ALU operation selected by funct3 alone (the funct7 alternates
  // SUB/SRA are resolved by the caller).
  function automatic logic [3:0] base_alu_op(input logic [2:0] funct3);
    logic [3:0] op;
    case (funct3)
      F3_ADD_SUB: op = ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/core_ctrl_fsm_if.sv
// Memory-side handshake bundle of the control sequencer: instruction
// fetch request/ack with the fetched word, and data access request/ack.
interface core_ctrl_fsm_if;
  logic [31:0] instr;
  logic        imem_req;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  instr, imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output instr, imem_ack, dmem_ack
  );
endinterface

// File: rtl/core_ctrl_fsm_alu_op_decode.sv
// Combinational map of {opcode, funct3, funct7} to ALU operation,
// operand-B select and instruction legality.
module alu_op_decode
  import core_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic       alu_src_imm,
  output logic       legal
);

  // Legality and ALU selection per supported instruction class
  always_comb begin
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    legal       = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        if (funct7 == F7_BASE) begin
          legal  = 1'b1;
          alu_op = base_alu_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          legal  = 1'b1;
          alu_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
          legal  = 1'b1;
          alu_op = ALU_SRA;
        end
      end
      OPC_OPIMM: begin
        alu_src_imm = 1'b1;
        alu_op      = base_alu_op(funct3);
        case (funct3)
          F3_SLL: legal = (funct7 == F7_BASE);
          F3_SRL_SRA: begin
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            if (funct7 == F7_ALT) alu_op = ALU_SRA;
          end
          default: legal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        alu_src_imm = 1'b1;
        legal       = (funct3 == F3_WORD);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// Optional: define CORE_CTRL_MEM_TIMEOUT_EN to trap after TIMEOUT_CYCLES
// consecutive MEM cycles without dmem_ack.
module core_ctrl_fsm
  import core_ctrl_pkg::*;
#(
  parameter int INSTRET_W = 32
`ifdef CORE_CTRL_MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  core_ctrl_fsm_if.master      bus,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 rf_we,
  output logic                 wb_sel,
  output logic                 alu_src_imm,
  output logic [3:0]           alu_op,
  output logic                 retire,
  output logic                 trap,
  output logic [INSTRET_W-1:0] instret
);

  state_t               state_reg;
  logic [6:0]           opcode_reg;
  logic [2:0]           funct3_reg;
  logic [6:0]           funct7_reg;
  logic                 trap_reg;
  logic [INSTRET_W-1:0] instret_reg;

  logic [3:0] dec_alu_op;
  logic       dec_src_imm;
  logic       dec_legal;
  logic       is_load;
  logic       is_store;

  // Register/immediate fields are consumed by the field decoder, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr[24:15], bus.instr[11:7]};

  assign is_load  = (opcode_reg == OPC_LOAD);
  assign is_store = (opcode_reg == OPC_STORE);

  alu_op_decode u_dec (
    .opcode      (opcode_reg),
    .funct3      (funct3_reg),
    .funct7      (funct7_reg),
    .alu_op      (dec_alu_op),
    .alu_src_imm (dec_src_imm),
    .legal       (dec_legal)
  );

`ifdef CORE_CTRL_MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_cnt_reg;
`endif

  // Per-state control outputs; everything is forced low during reset
  always_comb begin
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 1'b0;
    alu_src_imm  = 1'b0;
    alu_op       = ALU_ADD;
    retire       = 1'b0;
    if (!rst) begin
      case (state_reg)
        FETCH: begin
          bus.imem_req = 1'b1;
          ir_we        = bus.imem_ack;
        end
        EXEC: begin
          alu_op      = dec_alu_op;
          alu_src_imm = dec_src_imm;
        end
        MEM: begin
          alu_op       = dec_alu_op;
          alu_src_imm  = dec_src_imm;
          bus.dmem_req = 1'b1;
          bus.dmem_we  = is_store;
          // A store completes straight out of MEM, skipping WB.
          if (bus.dmem_ack && is_store) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end
        WB: begin
          alu_op      = dec_alu_op;
          alu_src_imm = dec_src_imm;
          rf_we       = 1'b1;
          pc_we       = 1'b1;
          retire      = 1'b1;
          wb_sel      = is_load;
        end
        default: ;
      endcase
    end
  end

  assign trap    = trap_reg & ~rst;
  assign instret = rst ? '0 : instret_reg;

  // Sequencer state, instruction register, trap flag and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= FETCH;
      opcode_reg  <= '0;
      funct3_reg  <= '0;
      funct7_reg  <= '0;
      trap_reg    <= 1'b0;
      instret_reg <= '0;
`ifdef CORE_CTRL_MEM_TIMEOUT_EN
      wait_cnt_reg <= '0;
`endif
    end else begin
      if (retire) instret_reg <= instret_reg + INSTRET_W'(1);
      case (state_reg)
        FETCH: begin
          if (bus.imem_ack) begin
            opcode_reg <= bus.instr[6:0];
            funct3_reg <= bus.instr[14:12];
            funct7_reg <= bus.instr[31:25];
            state_reg  <= DECODE;
          end
        end
        DECODE: begin
          if (dec_legal) begin
            state_reg <= EXEC;
          end else begin
            state_reg <= TRAP;
            trap_reg  <= 1'b1;
          end
        end
        EXEC: begin
          state_reg <= (is_load || is_store) ? MEM : WB;
`ifdef CORE_CTRL_MEM_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
        end
        MEM: begin
          if (bus.dmem_ack) begin
            state_reg <= is_load ? WB : FETCH;
          end
`ifdef CORE_CTRL_MEM_TIMEOUT_EN
          else begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
            if (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
              state_reg <= TRAP;
              trap_reg  <= 1'b1;
            end
          end
`endif
        end
        WB:      state_reg <= FETCH;
        default: state_reg <= TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed bench for core_ctrl_fsm: per-instruction latency, control
// outputs, handshakes, illegal-instruction trap and reset abort.
module tb_core_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_we, pc_we, rf_we, wb_sel, alu_src_imm, retire, trap;
  logic [3:0]  alu_op;
  logic [31:0] instret;

  core_ctrl_fsm_if bus();

  core_ctrl_fsm #(.INSTRET_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .alu_src_imm (alu_src_imm),
    .alu_op      (alu_op),
    .retire      (retire),
    .trap        (trap),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One clock cycle: drive acks just after the falling edge, then settle.
  task automatic cyc(input logic ia, input logic da);
    @(negedge clk);
    bus.imem_ack = ia;
    bus.dmem_ack = da;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_outputs", 32'({bus.imem_req, bus.dmem_req, bus.dmem_we, ir_we, pc_we, rf_we,
                              wb_sel, alu_src_imm, alu_op, retire, trap}), 32'h0);
    check("rst_instret", instret, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  // Runs one instruction with a zero-wait imem and a dmem that acks after
  // mem_wait stall cycles, then compares the observed behaviour.
  task automatic txn(input string name, input logic [31:0] word, input int mem_wait,
                     input int e_cycles, input logic [3:0] e_op, input logic e_imm,
                     input int e_dreq, input logic e_dwe, input int e_rfwe,
                     input logic e_wbsel, input logic [31:0] e_instret);
    int   cycles = 0, req_cnt = 0, dreq_n = 0, rfwe_n = 0;
    logic ir_we_c1 = 1'b0, imm3 = 1'b0, dwe_any = 1'b0, wbsel_ret = 1'b0, pcwe_ret = 1'b0;
    logic [3:0] op3 = 4'hF;
    bus.instr = word;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      #1;
      bus.imem_ack = bus.imem_req;
      bus.dmem_ack = bus.dmem_req && (req_cnt == mem_wait);
      if (bus.dmem_req) req_cnt++;
      #1;
      if (c == 1) ir_we_c1 = ir_we;
      if (c == 3) begin
        op3  = alu_op;
        imm3 = alu_src_imm;
      end
      if (bus.dmem_req) begin
        dreq_n++;
        dwe_any |= bus.dmem_we;
      end
      if (rf_we) rfwe_n++;
      if (retire) begin
        cycles    = c;
        wbsel_ret = wb_sel;
        pcwe_ret  = pc_we;
        break;
      end
    end
    @(posedge clk);
    #1;
    $display("txn %s instr=%08h wait=%0d cycles=%0d instret=%0d", name, word, mem_wait, cycles, instret);
    check({name, "_ir_we_c1"}, 32'(ir_we_c1), 32'h1);
    check({name, "_cycles"},   32'(cycles), 32'(e_cycles));
    check({name, "_alu_op"},   32'(op3), 32'(e_op));
    check({name, "_src_imm"},  32'(imm3), 32'(e_imm));
    check({name, "_dreq_n"},   32'(dreq_n), 32'(e_dreq));
    check({name, "_dmem_we"},  32'(dwe_any), 32'(e_dwe));
    check({name, "_rf_we_n"},  32'(rfwe_n), 32'(e_rfwe));
    check({name, "_wb_sel"},   32'(wbsel_ret), 32'(e_wbsel));
    check({name, "_pc_we"},    32'(pcwe_ret), 32'h1);
    check({name, "_instret"},  instret, e_instret);
  endtask

  // Illegal instruction: trap after DECODE, quiet afterwards, cleared by rst.
  task automatic trap_seq(input string name, input logic [31:0] word, input logic [31:0] e_instret);
    bus.instr = word;
    cyc(1'b1, 1'b0);
    check({name, "_ir_we"}, 32'(ir_we), 32'h1);
    cyc(1'b0, 1'b0);
    check({name, "_trap_decode"}, 32'(trap), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1);
      check({name, "_trap_set"}, 32'(trap), 32'h1);
      check({name, "_quiet"}, 32'({bus.imem_req, bus.dmem_req, pc_we, retire, rf_we}), 32'h0);
    end
    check({name, "_instret_frozen"}, instret, e_instret);
    $display("txn %s instr=%08h trap=%0d instret=%0d", name, word, trap, instret);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check({name, "_trap_in_rst"}, 32'(trap), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b0);
    check({name, "_req_after_rst"}, 32'(bus.imem_req), 32'h1);
    check({name, "_trap_cleared"}, 32'(trap), 32'h0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.instr    = 32'h0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    do_reset();

    //   name     word          wait cyc op imm dreq we rfwe wbsel instret
    txn("ADD",   32'h002081B3, 0, 4, 4'd0, 1'b0, 0, 1'b0, 1, 1'b0, 32'd1);
    txn("SUB",   32'h40208133, 0, 4, 4'd1, 1'b0, 0, 1'b0, 1, 1'b0, 32'd2);
    txn("SRAI",  32'h4010D093, 0, 4, 4'd7, 1'b1, 0, 1'b0, 1, 1'b0, 32'd3);
    txn("ADDI",  32'h00500093, 0, 4, 4'd0, 1'b1, 0, 1'b0, 1, 1'b0, 32'd4);
    txn("XOR",   32'h0020C1B3, 0, 4, 4'd5, 1'b0, 0, 1'b0, 1, 1'b0, 32'd5);
    txn("SRLI",  32'h0010D093, 0, 4, 4'd6, 1'b1, 0, 1'b0, 1, 1'b0, 32'd6);
    txn("LW_W3", 32'h0000A183, 3, 8, 4'd0, 1'b1, 4, 1'b0, 1, 1'b1, 32'd7);
    txn("SW_W0", 32'h0030A223, 0, 4, 4'd0, 1'b1, 1, 1'b1, 0, 1'b0, 32'd8);
    txn("LW_W0", 32'h0000A183, 0, 5, 4'd0, 1'b1, 1, 1'b0, 1, 1'b1, 32'd9);
    txn("AND",   32'h0020F1B3, 0, 4, 4'd9, 1'b0, 0, 1'b0, 1, 1'b0, 32'd10);
    txn("SW_W2", 32'h0030A223, 2, 6, 4'd0, 1'b1, 3, 1'b1, 0, 1'b0, 32'd11);

    trap_seq("ILL_ALL1", 32'hFFFFFFFF, 32'd11);
    trap_seq("ILL_SLL_ALT", 32'h40209133, 32'd0);
    txn("ADDI2", 32'h00500093, 0, 4, 4'd0, 1'b1, 0, 1'b0, 1, 1'b0, 32'd1);
    trap_seq("ILL_LB", 32'h00008183, 32'd1);
    trap_seq("ILL_SLLI_ALT", 32'h40109093, 32'd0);

    // Reset pulsed during a load's MEM wait aborts it without retiring.
    txn("ADD2", 32'h002081B3, 0, 4, 4'd0, 1'b0, 0, 1'b0, 1, 1'b0, 32'd1);
    bus.instr = 32'h0000A183;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("abort_mem1_req", 32'(bus.dmem_req), 32'h1);
    cyc(1'b0, 1'b0);
    check("abort_mem2_req", 32'(bus.dmem_req), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    bus.dmem_ack = 1'b1;
    #1;
    check("abort_rst_dreq", 32'(bus.dmem_req), 32'h0);
    check("abort_rst_retire", 32'(retire), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b0);
    check("abort_fetch_req", 32'(bus.imem_req), 32'h1);
    check("abort_dreq_off", 32'(bus.dmem_req), 32'h0);
    check("abort_instret", instret, 32'h0);
    $display("txn ABORT_LW instr=0000a183 instret=%0d", instret);
    txn("ADD3", 32'h002081B3, 0, 4, 4'd0, 1'b0, 0, 1'b0, 1, 1'b0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
